// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: thread count, data width,
// the arbiter FSM encoding and a small index-width helper.
package dmem_arbiter_pkg;

    localparam int NUM_THREADS = 4;
    localparam int DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first set request bit at or
// after the pointer (wrapping), returned both one-hot and as an index.
module dmem_arbiter_rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_THREADS,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the candidates farthest-first so the one nearest the pointer wins.
    always_comb begin
        cand     = 0;
        cand_idx = '0;
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (int'(ptr_i) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_REQ
// load/store units. Each access runs grant -> issue -> wait -> respond.
// Optional feature: define DMEM_ARB_PERF_EN to add saturating grant and
// stall counters (perf_grants, perf_stall).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_THREADS,
    parameter int DATA_WIDTH  = dmem_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]                      perf_grants,
    output logic [31:0]                      perf_stall
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(MEM_LATENCY);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   hs;
    logic                   cap_rdata;

    dmem_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Control state: FSM, round-robin pointer and load-latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state and all handshake/memory strobes; everything idles at 0.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        hs        = 1'b0;
        cap_rdata = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_grant;
                    hs        = 1'b1;
                    state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cnt_d     = CNT_W'(MEM_LATENCY - 1);
                state_d   = we_q ? ARB_RESP : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    cap_rdata = 1'b1;
                    state_d   = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Owner and returned load data are visible state, so they clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= '0;
            rdata_q <= '0;
        end else begin
            if (hs)        owner_q <= pick_idx;
            if (cap_rdata) rdata_q <= mem_rdata;
        end
    end

    // Request fields are only observed during ISSUE, so they need no reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            we_q    <= req_we[pick_idx];
            addr_q  <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != ARB_IDLE);

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Count handshakes, and cycles where someone waits without one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (hs)                              perf_grants_q <= sat_inc(perf_grants_q);
            else if (req_valid != '0)            perf_stall_q  <= sat_inc(perf_stall_q);
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-timing reference model.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int ML = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic              busy;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       perf_grants, perf_stall;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [DW-1:0] init_val(input int k);
        return (k == 3) ? 16'hBEEF : DW'((k * 16'h1111) ^ 16'h5A5A);
    endfunction

    // Memory with ML-cycle read latency; reseeded while reset is high.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_pipe [ML];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) mem[k] <= init_val(k);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
        for (int k = 1; k < ML; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[ML-1];

    // Bookkeeping and reference model state
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            free_at, rr;
    int            exp_mem_cyc, exp_rsp_cyc, exp_idx;
    logic          exp_we, exp_load;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_ld, ref_rdata;
    logic [DW-1:0] ref_mem [16];
    logic [N-1:0]  hs_last, keep_on, pend_v, pend_we;
    logic [AW-1:0] pend_a [N];
    logic [DW-1:0] pend_d [N];
    int            glog [$];
    int            ref_grants, ref_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        free_at     = 0;
        rr          = 0;
        exp_mem_cyc = -1;
        exp_rsp_cyc = -1;
        ref_rdata   = '0;
        hs_last     = '0;
        ref_grants  = 0;
        ref_stall   = 0;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_val(k);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rsp"},   32'(rsp_valid), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        check_eq({tag, "_mem"},   32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        check_eq({tag, "_pgrant"}, perf_grants, 32'd0);
        check_eq({tag, "_pstall"}, perf_stall, 32'd0);
`endif
    endtask

    // Per-cycle check: grants follow round-robin once the memory is free,
    // and each access produces its strobe and response at fixed offsets.
    task automatic model_check();
        logic [N-1:0] exp_ready, exp_rsp, hs;
        int           w;
        exp_ready = '0;
        exp_rsp   = '0;
        w         = -1;
        if (cyc >= free_at && req_valid != '0)
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(rr + k) % N]) w = (rr + k) % N;
        if (w >= 0) exp_ready[w] = 1'b1;
        check_eq("busy", 32'(busy), 32'(cyc < free_at));
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        if (cyc == exp_mem_cyc) begin
            check_eq("mem_en", 32'(mem_en), 32'd1);
            check_eq("mem_we", 32'(mem_we), 32'(exp_we));
            check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
            if (exp_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
        end else begin
            check_eq("mem_en_idle", 32'(mem_en), 32'd0);
        end
        if (cyc == exp_rsp_cyc) begin
            exp_rsp[exp_idx] = 1'b1;
            if (exp_load) ref_rdata = exp_ld;
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(ref_rdata));
`ifdef DMEM_ARB_PERF_EN
        check_eq("perf_grants", perf_grants, 32'(ref_grants));
        check_eq("perf_stall", perf_stall, 32'(ref_stall));
        if (w >= 0) ref_grants++;
        else if (req_valid != '0) ref_stall++;
`endif
        hs = req_valid & req_ready;
        for (int k = 0; k < N; k++) if (hs[k]) glog.push_back(k);
        hs_last = hs;
        if (w >= 0) begin
            rr          = (w + 1) % N;
            exp_we      = req_we[w];
            exp_load    = !req_we[w];
            exp_addr    = req_addr[w*AW +: AW];
            exp_wd      = req_wdata[w*DW +: DW];
            exp_idx     = w;
            exp_mem_cyc = cyc + 1;
            exp_rsp_cyc = cyc + (exp_we ? 2 : ML + 2);
            free_at     = cyc + (exp_we ? 3 : ML + 3);
            if (exp_we) ref_mem[exp_addr] = exp_wd;
            else        exp_ld = ref_mem[exp_addr];
        end
    endtask

    task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic queue_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_v[i]  = 1'b1;
        pend_we[i] = we;
        pend_a[i]  = a;
        pend_d[i]  = d;
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_last[i]) begin
                if (keep_on[i]) raise(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                else            req_valid[i] = 1'b0;
            end
            if (pend_v[i]) begin
                raise(i, pend_we[i], pend_a[i], pend_d[i]);
                pend_v[i] = 1'b0;
            end else if (rnd) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    raise(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                else if (req_valid[i] && !hs_last[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic drain();
        int n;
        n = 0;
        keep_on = '0;
        while (n < 300 && !(cyc >= free_at && req_valid == '0 && pend_v == '0)) begin
            step(1'b0);
            n++;
        end
        check_eq("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        req_valid = '0;
        keep_on   = '0;
        pend_v    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("rst_held");
        reset = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        keep_on   = '0;
        pend_v    = '0;
        pend_we   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Single load of mem[3] by requester 0
        queue_req(0, 1'b0, 4'd3, 16'h0);
        drain();
        check_eq("load_beef", 32'(rsp_rdata), 32'h0000BEEF);

        // Single store by requester 2; load data register must not move
        queue_req(2, 1'b1, 4'd5, 16'h1234);
        drain();
        check_eq("store_keeps_rdata", 32'(rsp_rdata), 32'h0000BEEF);
        check_eq("store_mem5", 32'(mem[5]), 32'h00001234);

        // All four requesters continuously valid from rr_ptr = 0
        do_reset();
        glog.delete();
        keep_on = '1;
        for (int i = 0; i < N; i++) queue_req(i, 1'b0, AW'(i), 16'h0);
        for (int n = 0; n < 200 && glog.size() < 5; n++) step(1'b0);
        check_eq("rr_timeout", 32'(glog.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("rr_order%0d", k), 32'(glog.size() > k ? glog[k] : 99), 32'(exp_order[k]));
        drain();

        // req3 raised while req1 is served beats a later req0
        do_reset();
        glog.delete();
        queue_req(1, 1'b0, 4'd9, 16'h0);
        step(1'b0);
        queue_req(3, 1'b1, 4'd2, 16'hCAFE);
        step(1'b0);
        step(1'b0);
        queue_req(0, 1'b0, 4'd2, 16'h0);
        drain();
        check_eq("busy_q_n", 32'(glog.size()), 32'd3);
        check_eq("busy_q_first", 32'(glog.size() > 0 ? glog[0] : 99), 32'd1);
        check_eq("busy_q_second", 32'(glog.size() > 1 ? glog[1] : 99), 32'd3);
        check_eq("busy_q_third", 32'(glog.size() > 2 ? glog[2] : 99), 32'd0);

        // Reset while a load sits in WAIT
        do_reset();
        queue_req(0, 1'b0, 4'd7, 16'h0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_eq("in_wait_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (6) step(1'b0);
        queue_req(1, 1'b0, 4'd3, 16'h0);
        drain();
        check_eq("after_reset_load", 32'(rsp_rdata), 32'h0000BEEF);

`ifdef DMEM_ARB_PERF_EN
        // Two loads contending: the second waits ML+2 cycles
        do_reset();
        queue_req(0, 1'b0, 4'd1, 16'h0);
        queue_req(1, 1'b0, 4'd2, 16'h0);
        drain();
        check_eq("perf_grants2", perf_grants, 32'd2);
        check_eq("perf_stall2", perf_stall, 32'(ML + 2));
`endif

        // Randomized traffic including withdrawals
        do_reset();
        repeat (3000) step(1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
